// File: rtl/regbank_alu_seq.sv
// regbank_alu_seq: multi-cycle controller running one reg-reg ALU op
// per transaction (read rs1/rs2, execute, write back rd).
module regbank_alu_seq #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 3,
  parameter int OP_W   = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   instr_op,
  input  logic [REG_AW-1:0] instr_rd,
  input  logic [REG_AW-1:0] instr_rs1,
  input  logic [REG_AW-1:0] instr_rs2,
  output logic [REG_AW-1:0] rf_raddr1,
  output logic [REG_AW-1:0] rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] last_result,
  output logic [CNT_W-1:0]  instr_count
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    EXEC,
    WRITE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [OP_W-1:0]   op_q;
  logic [REG_AW-1:0] rd_q;
  logic [REG_AW-1:0] rs1_q;
  logic [REG_AW-1:0] rs2_q;
  logic [DATA_W-1:0] opa_q;
  logic [DATA_W-1:0] opb_q;
  logic [DATA_W-1:0] res_q;
  logic [DATA_W-1:0] last_q;
  logic [CNT_W-1:0]  cnt_q;

  logic accept;

  assign accept = instr_valid & instr_ready;

  // State register; reset drops any in-flight instruction.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: fixed READ -> EXEC -> WRITE walk after acceptance.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = READ;
      READ:    state_d = EXEC;
      EXEC:    state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch fields, capture operands, result, retire stats.
  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q   <= '0;
      rd_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      opa_q  <= '0;
      opb_q  <= '0;
      res_q  <= '0;
      last_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (state_q == IDLE && accept) begin
        op_q  <= instr_op;
        rd_q  <= instr_rd;
        rs1_q <= instr_rs1;
        rs2_q <= instr_rs2;
      end
      if (state_q == READ) begin
        opa_q <= rf_rdata1;
        opb_q <= rf_rdata2;
      end
      if (state_q == EXEC) begin
        res_q <= alu_result;
      end
      if (state_q == WRITE) begin
        last_q <= res_q;
        cnt_q  <= cnt_q + 1'b1;
      end
    end
  end

  // Control outputs decoded from the state register only.
  always_comb begin
    instr_ready = 1'b0;
    busy        = 1'b1;
    rf_we       = 1'b0;
    done        = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        instr_ready = 1'b1;
        busy        = 1'b0;
      end
      (state_q == WRITE): begin
        rf_we = 1'b1;
        done  = 1'b1;
      end
      default: ;
    endcase
  end

  assign rf_raddr1   = rs1_q;
  assign rf_raddr2   = rs2_q;
  assign alu_a       = opa_q;
  assign alu_b       = opb_q;
  assign alu_op      = op_q;
  assign rf_waddr    = rd_q;
  assign rf_wdata    = res_q;
  assign last_result = last_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_regbank_alu_seq.sv
// tb_regbank_alu_seq: directed bench with behavioural register bank
// and ALU around regbank_alu_seq.
module tb_regbank_alu_seq;

  localparam int DW = 32;
  localparam int AW = 3;
  localparam int OW = 3;
  // Narrow counter so the wrap case is reachable in a short run.
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [OW-1:0] instr_op = '0;
  logic [AW-1:0] instr_rd = '0;
  logic [AW-1:0] instr_rs1 = '0;
  logic [AW-1:0] instr_rs2 = '0;
  logic [AW-1:0] rf_raddr1;
  logic [AW-1:0] rf_raddr2;
  logic [DW-1:0] rf_rdata1;
  logic [DW-1:0] rf_rdata2;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [OW-1:0] alu_op;
  logic [DW-1:0] alu_result;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          busy;
  logic          done;
  logic [DW-1:0] last_result;
  logic [CW-1:0] instr_count;

  logic          pre = 1'b1;
  logic [DW-1:0] rf [8];
  int            errors = 0;
  int            checks = 0;
  int            we_seen;

  regbank_alu_seq #(
    .DATA_W(DW),
    .REG_AW(AW),
    .OP_W  (OW),
    .CNT_W (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_op   (instr_op),
    .instr_rd   (instr_rd),
    .instr_rs1  (instr_rs1),
    .instr_rs2  (instr_rs2),
    .rf_raddr1  (rf_raddr1),
    .rf_raddr2  (rf_raddr2),
    .rf_rdata1  (rf_rdata1),
    .rf_rdata2  (rf_rdata2),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .busy       (busy),
    .done       (done),
    .last_result(last_result),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
      rf[1] <= 32'd5;
      rf[2] <= 32'd7;
    end else if (rf_we) begin
      rf[rf_waddr] <= rf_wdata;
    end
  end

  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  always_comb begin
    alu_result = '0;
    case (alu_op)
      3'd0:    alu_result = alu_a + alu_b;
      3'd1:    alu_result = alu_a - alu_b;
      3'd2:    alu_result = alu_a & alu_b;
      3'd3:    alu_result = alu_a | alu_b;
      3'd4:    alu_result = alu_a ^ alu_b;
      default: alu_result = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nclk();
    @(negedge clk);
  endtask

  task automatic setf(input logic [OW-1:0] op, input logic [AW-1:0] rd,
                      input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
    instr_op  = op;
    instr_rd  = rd;
    instr_rs1 = rs1;
    instr_rs2 = rs2;
  endtask

  // Full single transaction with valid dropped right after acceptance.
  task automatic issue(input logic [OW-1:0] op, input logic [AW-1:0] rd,
                       input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic [DW-1:0] exp);
    setf(op, rd, rs1, rs2);
    instr_valid = 1'b1;
    nclk();
    instr_valid = 1'b0;
    nclk();
    nclk();
    chk("iss_done", {31'd0, done}, 32'd1);
    chk("iss_wdata", rf_wdata, exp);
    nclk();
  endtask

  initial begin
    // Reset with valid asserted: nothing may be accepted.
    @(negedge clk);
    setf(3'd0, 3'd3, 3'd1, 3'd2);
    instr_valid = 1'b1;
    nclk();
    nclk();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_we", {31'd0, rf_we}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_cnt", {28'd0, instr_count}, 32'd0);
    chk("rst_last", last_result, 32'd0);
    chk("rst_raddr1", {29'd0, rf_raddr1}, 32'd0);
    instr_valid = 1'b0;
    pre = 1'b0;
    rst = 1'b1;
    nclk();

    // Single add: r3 = r1 + r2 = 12.
    setf(3'd0, 3'd3, 3'd1, 3'd2);
    instr_valid = 1'b1;
    nclk();
    instr_valid = 1'b0;
    chk("s_read_busy", {31'd0, busy}, 32'd1);
    chk("s_read_ready", {31'd0, instr_ready}, 32'd0);
    chk("s_raddr2", {29'd0, rf_raddr2}, 32'd2);
    nclk();
    chk("s_exec_we", {31'd0, rf_we}, 32'd0);
    chk("s_alu_a", alu_a, 32'd5);
    chk("s_alu_b", alu_b, 32'd7);
    nclk();
    chk("s_we", {31'd0, rf_we}, 32'd1);
    chk("s_waddr", {29'd0, rf_waddr}, 32'd3);
    chk("s_wdata", rf_wdata, 32'd12);
    chk("s_done", {31'd0, done}, 32'd1);
    nclk();
    chk("s_ready", {31'd0, instr_ready}, 32'd1);
    chk("s_done_lo", {31'd0, done}, 32'd0);
    chk("s_r3", rf[3], 32'd12);
    chk("s_cnt", {28'd0, instr_count}, 32'd1);
    chk("s_last", last_result, 32'd12);

    // Busy ignore: r4 = r2 - r1 = 2; a pulse during READ/EXEC is dropped.
    setf(3'd1, 3'd4, 3'd2, 3'd1);
    instr_valid = 1'b1;
    nclk();
    setf(3'd0, 3'd5, 3'd1, 3'd1);
    nclk();
    instr_valid = 1'b0;
    chk("bi_exec_b", alu_b, 32'd5);
    nclk();
    chk("bi_waddr", {29'd0, rf_waddr}, 32'd4);
    chk("bi_wdata", rf_wdata, 32'd2);
    nclk();
    nclk();
    chk("bi_r4", rf[4], 32'd2);
    chk("bi_r5", rf[5], 32'd0);
    chk("bi_cnt", {28'd0, instr_count}, 32'd2);
    chk("bi_idle", {31'd0, busy}, 32'd0);

    // Back-to-back with valid held: r1=r1+r1 (10), r6=r1^r2 (0xD),
    // r7=r3&r6 (12). Each acceptance 4 cycles after the previous.
    setf(3'd0, 3'd1, 3'd1, 3'd1);
    instr_valid = 1'b1;
    nclk();
    setf(3'd4, 3'd6, 3'd1, 3'd2);
    chk("bb0_busy", {31'd0, busy}, 32'd1);
    nclk();
    nclk();
    chk("bb0_wdata", rf_wdata, 32'd10);
    nclk();
    chk("bb1_ready", {31'd0, instr_ready}, 32'd1);
    chk("bb1_r1", rf[1], 32'd10);
    nclk();
    setf(3'd2, 3'd7, 3'd3, 3'd6);
    chk("bb1_busy", {31'd0, busy}, 32'd1);
    nclk();
    nclk();
    chk("bb1_wdata", rf_wdata, 32'hD);
    nclk();
    chk("bb2_ready", {31'd0, instr_ready}, 32'd1);
    nclk();
    instr_valid = 1'b0;
    nclk();
    nclk();
    chk("bb2_wdata", rf_wdata, 32'd12);
    nclk();
    chk("bb_r6", rf[6], 32'hD);
    chk("bb_r7", rf[7], 32'd12);
    chk("bb_cnt", {28'd0, instr_count}, 32'd5);
    nclk();
    chk("bb_no_more", {31'd0, busy}, 32'd0);

    // Reset during EXEC: r2 = r1 + r1 must not be written.
    setf(3'd0, 3'd2, 3'd1, 3'd1);
    instr_valid = 1'b1;
    nclk();
    instr_valid = 1'b0;
    nclk();
    rst = 1'b0;
    we_seen = 0;
    nclk();
    if (rf_we) we_seen++;
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_done", {31'd0, done}, 32'd0);
    chk("mr_cnt", {28'd0, instr_count}, 32'd0);
    chk("mr_last", last_result, 32'd0);
    rst = 1'b1;
    nclk();
    if (rf_we) we_seen++;
    nclk();
    if (rf_we) we_seen++;
    chk("mr_we_seen", we_seen, 32'd0);
    chk("mr_r2", rf[2], 32'd7);

    // Counter wrap: 15 ops reach all-ones, the 16th wraps to zero.
    for (int i = 0; i < 15; i++) issue(3'd3, 3'd5, 3'd1, 3'd2, 32'hF);
    chk("wr_full", {28'd0, instr_count}, 32'hF);
    issue(3'd4, 3'd5, 3'd1, 3'd2, 32'hD);
    chk("wr_zero", {28'd0, instr_count}, 32'd0);
    chk("wr_last", last_result, 32'hD);
    chk("wr_r5", rf[5], 32'hD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
